// File: rtl/rdbuf_pp_if.sv
`default_nettype none
// ============================================================================
// Module   : rdbuf_pp_if
// Brief    : Engine-write / write-back-drain bundle of the ping-pong buffer.
//            The slave modport is the buffer's view; master is the peer view.
// Revision : 1.0 - initial release
// ============================================================================
interface rdbuf_pp_if #(
    parameter int WR_W  = 32,
    parameter int RATIO = 2,
    parameter int DEPTH = 256
);
    localparam int RD_W  = WR_W * RATIO;
    localparam int AW_RD = $clog2(DEPTH);
    localparam int AW_WR = AW_RD + $clog2(RATIO);
    localparam int BE_W  = WR_W / 8;

    logic              wr_en;
    logic [BE_W-1:0]   wr_be;
    logic [AW_WR-1:0]  wr_addr;
    logic [WR_W-1:0]   wr_data;
    logic              wr_commit;
    logic [AW_RD:0]    wr_len;
    logic              wr_ready;
    logic              rd_valid;
    logic              rd_ready;
    logic [RD_W-1:0]   rd_data;
    logic              rd_last;
    logic              fill_bank;
    logic [1:0]        err;

    modport slave (
        input  wr_en, wr_be, wr_addr, wr_data, wr_commit, wr_len, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_last, fill_bank, err
    );

    modport master (
        output wr_en, wr_be, wr_addr, wr_data, wr_commit, wr_len, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_last, fill_bank, err
    );
endinterface
`default_nettype wire

// File: rtl/rdbuf_pp.sv
`default_nettype none
// ============================================================================
// Module   : rdbuf_pp
// Brief    : Double-buffered width-converting result buffer. The engine fills
//            one bank with narrow byte-enabled writes while the other bank is
//            drained as a wide valid/ready stream by an internal sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module rdbuf_pp #(
    parameter int WR_W  = 32,
    parameter int RATIO = 2,
    parameter int DEPTH = 256
) (
    input  wire logic  clk,
    input  wire logic  rst,
    rdbuf_pp_if.slave  bus
);
    localparam int RD_W   = WR_W * RATIO;
    localparam int AW_RD  = $clog2(DEPTH);
    localparam int LW     = $clog2(RATIO);
    localparam int AW_WR  = AW_RD + LW;
    localparam int BE_W   = WR_W / 8;
    localparam int LANE_W = (LW > 0) ? LW : 1;
    localparam logic [AW_RD:0] LEN_MAX = (AW_RD + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    // Both banks share one array; the bank index is the address MSB.
    logic [RD_W-1:0]  r_mem [2*DEPTH];

    logic [1:0]       r_full;
    logic [AW_RD:0]   r_len [2];
    logic             r_fill;
    logic [1:0]       r_err;

    state_t           r_state;
    logic             r_drain;
    logic [AW_RD:0]   r_issue_cnt;

    // Stage holding the word read from RAM last cycle.
    logic             r_q_valid;
    logic             r_q_last;
    logic [RD_W-1:0]  r_q_data;

    // Two-entry output skid: out is the visible beat, sk the overflow slot.
    logic             r_out_valid;
    logic             r_out_last;
    logic [RD_W-1:0]  r_out_data;
    logic             r_sk_valid;
    logic             r_sk_last;
    logic [RD_W-1:0]  r_sk_data;

    logic             w_wr_ready;
    logic             w_wr_acc;
    logic             w_commit_acc;
    logic [AW_RD:0]   w_len_clip;
    logic [AW_RD-1:0] w_word;
    logic [LANE_W-1:0] w_lane;
    logic             w_pop;
    logic             w_done;
    logic [2:0]       w_occ;
    logic             w_issue;
    logic [AW_RD:0]   w_rd_addr;

    generate
        if (RATIO > 1) begin : g_lane
            assign w_lane = bus.wr_addr[LANE_W-1:0];
        end else begin : g_no_lane
            assign w_lane = '0;
        end
    endgenerate

    assign w_word       = bus.wr_addr[AW_WR-1:LW];
    assign w_wr_ready   = ~r_full[r_fill];
    assign w_wr_acc     = bus.wr_en & w_wr_ready;
    assign w_commit_acc = bus.wr_commit & w_wr_ready & (bus.wr_len != '0);
    assign w_len_clip   = (bus.wr_len > LEN_MAX) ? LEN_MAX : bus.wr_len;

    assign w_pop  = r_out_valid & bus.rd_ready;
    assign w_done = w_pop & r_out_last;

    // Occupancy the skid will hold after this edge, counting the word in
    // flight from RAM; a new read is issued only if it still has room.
    assign w_occ = {2'b00, r_out_valid} + {2'b00, r_sk_valid}
                 + {2'b00, r_q_valid} - {2'b00, w_pop};
    assign w_issue = ((r_state == S_READ) || (r_state == S_STREAM))
                   && (r_issue_cnt != r_len[r_drain])
                   && (w_occ < 3'd2);
    assign w_rd_addr = {r_drain, r_issue_cnt[AW_RD-1:0]};

    // Storage: byte-lane writes into the fill bank, registered drain reads.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int l = 0; l < RATIO; l++) begin
                for (int k = 0; k < BE_W; k++) begin
                    if ((w_lane == LANE_W'(l)) && bus.wr_be[k]) begin
                        r_mem[{r_fill, w_word}][l*WR_W + k*8 +: 8] <= bus.wr_data[k*8 +: 8];
                    end
                end
            end
        end
        if (w_issue) begin
            r_q_data <= r_mem[w_rd_addr];
        end
    end

    // Bank ownership: full flags, stored lengths, fill pointer, sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 2'b00;
            r_len  <= '{default: '0};
            r_fill <= 1'b0;
            r_err  <= 2'b00;
        end else begin
            if (w_done) begin
                r_full[r_drain] <= 1'b0;
            end
            if (w_commit_acc) begin
                r_full[r_fill] <= 1'b1;
                r_len[r_fill]  <= w_len_clip;
                r_fill         <= ~r_fill;
            end
            r_err[0] <= r_err[0] | ((bus.wr_en | bus.wr_commit) & ~w_wr_ready);
            r_err[1] <= r_err[1] | (bus.wr_commit & (bus.wr_len == '0));
        end
    end

    // Drain sequencer: waits for the drain bank to fill, walks its words,
    // hands over to the other bank once the last beat is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_drain     <= 1'b0;
            r_issue_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_issue_cnt <= '0;
                    if (r_full[r_drain]) begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                    end
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                    end
                    if (w_done) begin
                        r_state     <= S_IDLE;
                        r_drain     <= ~r_drain;
                        r_issue_cnt <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag the RAM read stage: valid when issued, last on the final word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_valid <= 1'b0;
            r_q_last  <= 1'b0;
        end else begin
            r_q_valid <= w_issue;
            r_q_last  <= (r_issue_cnt + 1'b1) == r_len[r_drain];
        end
    end

    // Output skid: refill the visible beat when free, park extra word in sk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_sk_valid  <= 1'b0;
            r_sk_last   <= 1'b0;
            r_sk_data   <= '0;
        end else if (!r_out_valid || w_pop) begin
            if (r_sk_valid) begin
                r_out_valid <= 1'b1;
                r_out_last  <= r_sk_last;
                r_out_data  <= r_sk_data;
                r_sk_valid  <= r_q_valid;
                r_sk_last   <= r_q_last;
                if (r_q_valid) begin
                    r_sk_data <= r_q_data;
                end
            end else begin
                r_out_valid <= r_q_valid;
                r_out_last  <= r_q_valid & r_q_last;
                if (r_q_valid) begin
                    r_out_data <= r_q_data;
                end
            end
        end else if (r_q_valid) begin
            r_sk_valid <= 1'b1;
            r_sk_last  <= r_q_last;
            r_sk_data  <= r_q_data;
        end
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.rd_valid  = r_out_valid;
    assign bus.rd_data   = r_out_data;
    assign bus.rd_last   = r_out_last;
    assign bus.fill_bank = r_fill;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rdbuf_pp.sv
`default_nettype none
// ============================================================================
// Module   : tb_rdbuf_pp
// Brief    : Randomised self-checking bench for rdbuf_pp against a bank-level
//            reference model (bank images, full flags, expected-beat queue).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rdbuf_pp;
    localparam int WR_W  = 32;
    localparam int RATIO = 2;
    localparam int DEPTH = 32;
    localparam int AW_RD = $clog2(DEPTH);
    localparam int AW_WR = AW_RD + $clog2(RATIO);
    localparam int RD_W  = WR_W * RATIO;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rdbuf_pp_if #(.WR_W(WR_W), .RATIO(RATIO), .DEPTH(DEPTH)) bus ();

    rdbuf_pp #(.WR_W(WR_W), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [RD_W-1:0] m_bank [2][DEPTH];
    bit              m_full [2];
    int              m_fill  = 0;
    int              m_drain = 0;
    logic [1:0]      m_err   = 2'b00;
    logic [RD_W:0]   exp_q [$];
    int              beats   = 0;
    bit              rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Beat monitor: every visible beat must equal the queue head; pop on accept.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", 1, 0);
            end else begin
                check("beat", {bus.rd_last, bus.rd_data}, exp_q[0]);
                if (bus.rd_ready) begin
                    if (exp_q[0][RD_W]) begin
                        m_full[m_drain] = 1'b0;
                        m_drain ^= 1;
                    end
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.rd_ready = 1'($urandom_range(0, 1));
        if (!rst) begin
            check("wr_ready", bus.wr_ready, !m_full[m_fill]);
            check("fill_bank", bus.fill_bank, m_fill[0]);
            check("err", bus.err, m_err);
        end
    endtask

    task automatic wr(input int a, input logic [WR_W-1:0] d, input logic [3:0] be);
        logic [RD_W-1:0] w;
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW_WR'(a);
        bus.wr_data = d;
        bus.wr_be   = be;
        if (!m_full[m_fill]) begin
            w = m_bank[m_fill][a / RATIO];
            for (int k = 0; k < 4; k++)
                if (be[k]) w[(a % RATIO) * WR_W + k * 8 +: 8] = d[k*8 +: 8];
            m_bank[m_fill][a / RATIO] = w;
        end else begin
            m_err[0] = 1'b1;
        end
        cyc();
        bus.wr_en = 1'b0;
    endtask

    task automatic commit(input int len);
        int n;
        bus.wr_commit = 1'b1;
        bus.wr_len    = (AW_RD + 1)'(len);
        if (m_full[m_fill]) m_err[0] = 1'b1;
        if (len == 0) m_err[1] = 1'b1;
        if (!m_full[m_fill] && len != 0) begin
            n = (len > DEPTH) ? DEPTH : len;
            for (int i = 0; i < n; i++)
                exp_q.push_back({(i == n - 1), m_bank[m_fill][i]});
            m_full[m_fill] = 1'b1;
            m_fill ^= 1;
        end
        cyc();
        bus.wr_commit = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        m_fill  = 0;
        m_drain = 0;
        m_err   = 2'b00;
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) cyc();
        check("drain_done", exp_q.size(), 0);
        check("idle_valid", bus.rd_valid, 0);
    endtask

    task automatic fill_seq(input int n, input logic [WR_W-1:0] base);
        for (int i = 0; i < n; i++) wr(i, base + WR_W'(i), 4'hF);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_be = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.wr_commit = 1'b0; bus.wr_len = '0; bus.rd_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check("rst_wr_ready", bus.wr_ready, 1);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_last", bus.rd_last, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_fill_bank", bus.fill_bank, 0);
        check("rst_err", bus.err, 0);

        // Single bank, latency and lane order.
        bus.rd_ready = 1'b1;
        fill_seq(8, 32'h1000);
        commit(4);
        check("lat_t0", bus.rd_valid, 0);
        cyc();
        cyc();
        check("lat_t2", bus.rd_valid, 0);
        cyc();
        check("lat_t3", bus.rd_valid, 1);
        check("first_beat", bus.rd_data, 64'h00001001_00001000);
        wait_drain(50);

        // Byte enables on the upper lane.
        wr(0, 32'hFFFFFFFF, 4'hF);
        wr(1, 32'hFFFFFFFF, 4'hF);
        wr(1, 32'h11223344, 4'h5);
        commit(1);
        for (int i = 0; i < 10 && !bus.rd_valid; i++) cyc();
        check("be_word", bus.rd_data, 64'hFF22FF44_FFFFFFFF);
        wait_drain(50);

        // Ping-pong with backpressure.
        bus.rd_ready = 1'b0;
        fill_seq(2 * DEPTH, 32'hA000_0000);
        commit(DEPTH);
        fill_seq(2 * DEPTH, 32'hB000_0000);
        commit(DEPTH);
        check("pp_wr_ready", bus.wr_ready, 0);
        wr(0, 32'hDEAD_BEEF, 4'hF);
        check("pp_err0", bus.err[0], 1);
        repeat (5) cyc();
        bus.rd_ready = 1'b1;
        wait_drain(4 * DEPTH + 50);

        // Random data, random backpressure over three banks.
        rand_rdy = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 500 && !bus.wr_ready; i++) cyc();
            check("rnd_ready", bus.wr_ready, 1);
            for (int i = 0; i < 34; i++) wr(i, $urandom, 4'hF);
            for (int i = 0; i < 10; i++)
                wr($urandom_range(0, 33), $urandom, 4'($urandom_range(0, 15)));
            commit(17);
        end
        wait_drain(2000);
        rand_rdy = 1'b0;
        bus.rd_ready = 1'b1;

        // Zero length commit, then oversize length.
        commit(0);
        repeat (5) cyc();
        check("len0_err1", bus.err[1], 1);
        check("len0_valid", bus.rd_valid, 0);
        fill_seq(2 * DEPTH, 32'hC000_0000);
        commit(DEPTH + 5);
        wait_drain(4 * DEPTH);

        // Reset in the middle of a drain.
        fill_seq(20, 32'hD000_0000);
        begin
            int b0;
            b0 = beats;
            commit(10);
            for (int i = 0; i < 100 && beats < b0 + 5; i++) cyc();
            check("mid_beats", beats - b0, 5);
        end
        rst = 1'b1;
        model_reset();
        cyc();
        check("mid_rst_valid", bus.rd_valid, 0);
        check("mid_rst_ready", bus.wr_ready, 1);
        check("mid_rst_fill", bus.fill_bank, 0);
        rst = 1'b0;
        cyc();
        fill_seq(4, 32'hE000_0000);
        commit(2);
        wait_drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rdbuf_pp.md
# rdbuf_pp

Parametrised double-buffered width-converting result buffer between the compute engine (narrow byte-enabled writes) and the AXI write-back master (wide valid/ready stream). Successor of the single-bank 2k read buffer: banks ping-pong so the engine fills one bank while the other drains. A hardware drain sequencer replaces external AXI-side addressing, with commit/length handshake and overflow detection.

## Interface
- WR_W, 32, compute-side word width (multiple of 8)
- RATIO, 2, RD_W = WR_W*RATIO; power of 2, 1..8
- DEPTH, 256, RD_W words per bank; power of 2
- (derived) AW_RD = log2(DEPTH), AW_WR = AW_RD + log2(RATIO), BE_W = WR_W/8

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe into current fill bank
- wr_be  in  BE_W  byte enables for wr_data
- wr_addr  in  AW_WR  narrow-word address within fill bank
- wr_data  in  WR_W  write data
- wr_commit  in  1  one-cycle pulse: fill bank complete, hand to drain
- wr_len  in  AW_RD+1  RD_W words to drain from committed bank, 1..DEPTH
- wr_ready  out  1  fill bank free to accept writes/commit
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  downstream accepts beat
- rd_data  out  RD_W  drained word
- rd_last  out  1  final beat of a bank
- fill_bank  out  1  index of bank currently filling
- err  out  2  sticky: [0] write/commit while wr_ready=0, [1] wr_len==0 commit

## Operation
- Two banks, each DEPTH x RD_W, per-bank full flag full[b], stored length len[b].
- Write mapping: word = wr_addr[AW_WR-1:log2(RATIO)], lane = wr_addr[log2(RATIO)-1:0]; lane 0 occupies rd_data[WR_W-1:0] (little-endian lanes). Byte k of wr_data written only when wr_be[k].
- wr_ready = !full[fill_bank]. Writes with wr_ready=0 are dropped, set err[0].
- Commit accepted (wr_commit & wr_ready & wr_len!=0): full[fill_bank]<=1, len<=min(wr_len,DEPTH), fill_bank toggles. wr_len==0: ignored, err[1] set, no toggle. wr_en in commit cycle is still written to the old bank.
- Drain FSM states: IDLE -> READ (issue RAM read addr 0 of drain bank d) -> STREAM -> IDLE.
  - IDLE: if full[d], go READ. d starts 0 and toggles after each bank completes (banks drain in commit order).
  - STREAM: 1-cycle RAM latency hidden by 2-entry output skid; sustained 1 beat/cycle while rd_ready=1. Read address advances only when skid not full.
  - Beat accepted on rd_valid & rd_ready. rd_last high with beat index len[d]-1. On its acceptance: full[d]<=0, d toggles, FSM to IDLE.
- rd_data/rd_valid/rd_last held stable while rd_valid & !rd_ready.
- Commit and drain completion in same cycle: both take effect; wr_ready reflects cleared flag next cycle.
- err cleared only by rst.

## Timing
- Reset values: wr_ready=1, rd_valid=0, rd_last=0, rd_data=0, fill_bank=0, err=0, full=0, FSM IDLE, d=0. RAM contents not cleared.
- rst mid-drain: rd_valid=0 the cycle after rst sampled; pending bank data discarded.
- Commit sampled edge t, drain idle: full set edge t, FSM READ edge t+1, first rd_valid=1 after edge t+3.
- Commit while drain busy on other bank: that bank starts READ the cycle after previous rd_last accepted; first beat 2 cycles later.
- wr_ready drops the cycle after commit if the new fill bank is still full; rises the cycle after that bank's rd_last handshake.
- Write-to-read: a write at edge t is visible to a drain read issued at t+1 or later.

## Test plan
- Single bank: RATIO=2, write addr 0..7 data 0x1000+addr, be=0xF, commit len=4, rd_ready=1 -> beats 0x00001001_00001000, ..._00001003_00001002, ..., rd_last on beat 3, first rd_valid 3 cycles after commit.
- Byte enables: pre-fill word 0 with 0xFFFFFFFF both lanes, rewrite addr 1 be=0x5 data 0x11223344, commit len=1 -> rd_data 0xFF22FF44_FFFFFFFF.
- Ping-pong backpressure: commit bank 0 len=DEPTH, rd_ready=0; fill bank 1, commit -> wr_ready=0; write attempt sets err[0]; release rd_ready -> 2*DEPTH beats in order, wr_ready=1 the cycle after the first rd_last.
- Random rd_ready (50%) over 3 banks of len 17 -> data matches model, no beat lost/duplicated, outputs stable while stalled.
- Commit wr_len=0 -> err[1]=1, fill_bank unchanged, no rd_valid; commit wr_len=DEPTH+5 -> exactly DEPTH beats.
- Assert rst on beat 5 of 10 -> rd_valid=0 next cycle, wr_ready=1, fill_bank=0; subsequent commit len=2 drains bank 0 normally.
